// File: rtl/smem_req_arb.sv
// Shared-memory request arbiter: round-robin grant of whole-warp batches through a
// 2-entry skid buffer, with source index appended to the tag and responses routed back by it.
module smem_req_arb #(
    parameter int NUM_INPUTS    = 2,
    parameter int NUM_REQS      = 4,
    parameter int WORD_SIZE     = 4,
    parameter int ADDR_WIDTH    = 30,
    parameter int TAG_IN_WIDTH  = 10,
    parameter int SRC_BITS      = $clog2(NUM_INPUTS),
    parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + SRC_BITS
) (
    input  logic                                       clk,
    input  logic                                       rst_ni,
    input  logic [NUM_INPUTS*NUM_REQS-1:0]             in_req_valid,
    input  logic [NUM_INPUTS*NUM_REQS-1:0]             in_req_rw,
    input  logic [NUM_INPUTS*NUM_REQS*ADDR_WIDTH-1:0]  in_req_addr,
    input  logic [NUM_INPUTS*NUM_REQS*WORD_SIZE-1:0]   in_req_byteen,
    input  logic [NUM_INPUTS*NUM_REQS*8*WORD_SIZE-1:0] in_req_data,
    input  logic [NUM_INPUTS*NUM_REQS*TAG_IN_WIDTH-1:0] in_req_tag,
    output logic [NUM_INPUTS*NUM_REQS-1:0]             in_req_ready,
    output logic [NUM_REQS-1:0]                        out_req_valid,
    output logic [NUM_REQS-1:0]                        out_req_rw,
    output logic [NUM_REQS*ADDR_WIDTH-1:0]             out_req_addr,
    output logic [NUM_REQS*WORD_SIZE-1:0]              out_req_byteen,
    output logic [NUM_REQS*8*WORD_SIZE-1:0]            out_req_data,
    output logic [NUM_REQS*TAG_OUT_WIDTH-1:0]          out_req_tag,
    input  logic [NUM_REQS-1:0]                        out_req_ready,
    input  logic                                       mem_rsp_valid,
    input  logic [NUM_REQS-1:0]                        mem_rsp_tmask,
    input  logic [NUM_REQS*8*WORD_SIZE-1:0]            mem_rsp_data,
    input  logic [TAG_OUT_WIDTH-1:0]                   mem_rsp_tag,
    output logic                                       mem_rsp_ready,
    output logic [NUM_INPUTS-1:0]                      in_rsp_valid,
    output logic [NUM_INPUTS*NUM_REQS-1:0]             in_rsp_tmask,
    output logic [NUM_INPUTS*NUM_REQS*8*WORD_SIZE-1:0] in_rsp_data,
    output logic [NUM_INPUTS*TAG_IN_WIDTH-1:0]         in_rsp_tag,
    input  logic [NUM_INPUTS-1:0]                      in_rsp_ready
);

    localparam int DATA_WIDTH = 8 * WORD_SIZE;

    // Handshake: a batch moves when valid and ready are both high at a clock edge; a
    // master holds its whole batch stable until accepted, and ready never waits on
    // downstream ready combinationally.

    logic [NUM_REQS-1:0]              m_valid  [NUM_INPUTS];
    logic [NUM_REQS-1:0]              m_rw     [NUM_INPUTS];
    logic [NUM_REQS*ADDR_WIDTH-1:0]   m_addr   [NUM_INPUTS];
    logic [NUM_REQS*WORD_SIZE-1:0]    m_byteen [NUM_INPUTS];
    logic [NUM_REQS*DATA_WIDTH-1:0]   m_data   [NUM_INPUTS];
    logic [NUM_REQS*TAG_IN_WIDTH-1:0] m_tag    [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]            req;

    for (genvar m = 0; m < NUM_INPUTS; m++) begin : g_unpack
        assign m_valid[m]  = in_req_valid[m*NUM_REQS +: NUM_REQS];
        assign m_rw[m]     = in_req_rw[m*NUM_REQS +: NUM_REQS];
        assign m_addr[m]   = in_req_addr[m*NUM_REQS*ADDR_WIDTH +: NUM_REQS*ADDR_WIDTH];
        assign m_byteen[m] = in_req_byteen[m*NUM_REQS*WORD_SIZE +: NUM_REQS*WORD_SIZE];
        assign m_data[m]   = in_req_data[m*NUM_REQS*DATA_WIDTH +: NUM_REQS*DATA_WIDTH];
        assign m_tag[m]    = in_req_tag[m*NUM_REQS*TAG_IN_WIDTH +: NUM_REQS*TAG_IN_WIDTH];
        assign req[m]      = |m_valid[m];
    end

    function automatic logic [SRC_BITS-1:0] wrap_add(input logic [SRC_BITS-1:0] base,
                                                     input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_INPUTS) sum = sum - NUM_INPUTS;
        return SRC_BITS'(sum);
    endfunction

    logic [SRC_BITS-1:0] rr_ptr;
    logic [SRC_BITS-1:0] grant;
    logic                grant_found;
    logic                buf_ready;
    logic                accept;
    logic                fire;
    logic [1:0]          count;
    logic [1:0]          count_next;
    logic                wr_ptr;
    logic                rd_ptr;

    // Highest offset is scanned first so the nearest requester at/after rr_ptr wins last.
    always_comb begin
        grant       = rr_ptr;
        grant_found = 1'b0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (req[wrap_add(rr_ptr, i)]) begin
                grant       = wrap_add(rr_ptr, i);
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        in_req_ready = '0;
        for (int m = 0; m < NUM_INPUTS; m++) begin
            if (grant_found && grant == SRC_BITS'(m)) begin
                in_req_ready[m*NUM_REQS +: NUM_REQS] = {NUM_REQS{buf_ready}};
            end
        end
    end

    logic [NUM_REQS*TAG_OUT_WIDTH-1:0] sel_tag;
    for (genvar l = 0; l < NUM_REQS; l++) begin : g_tag
        assign sel_tag[l*TAG_OUT_WIDTH +: TAG_OUT_WIDTH] =
            {m_tag[grant][l*TAG_IN_WIDTH +: TAG_IN_WIDTH], grant};
    end

    assign accept     = grant_found && buf_ready;
    assign fire       = (|out_req_valid) && out_req_ready[0];
    assign count_next = count + {1'b0, accept} - {1'b0, fire};

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            buf_ready <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= ~wr_ptr;
                rr_ptr <= wrap_add(grant, 1);
            end
            if (fire) rd_ptr <= ~rd_ptr;
            count     <= count_next;
            buf_ready <= (count_next < 2'd2);
        end
    end

    logic [NUM_REQS-1:0]               slot_valid  [2];
    logic [NUM_REQS-1:0]               slot_rw     [2];
    logic [NUM_REQS*ADDR_WIDTH-1:0]    slot_addr   [2];
    logic [NUM_REQS*WORD_SIZE-1:0]     slot_byteen [2];
    logic [NUM_REQS*DATA_WIDTH-1:0]    slot_data   [2];
    logic [NUM_REQS*TAG_OUT_WIDTH-1:0] slot_tag    [2];

    // Payload slots need no reset: the count gates every use of them.
    always_ff @(posedge clk) begin
        if (accept) begin
            slot_valid[wr_ptr]  <= m_valid[grant];
            slot_rw[wr_ptr]     <= m_rw[grant];
            slot_addr[wr_ptr]   <= m_addr[grant];
            slot_byteen[wr_ptr] <= m_byteen[grant];
            slot_data[wr_ptr]   <= m_data[grant];
            slot_tag[wr_ptr]    <= sel_tag;
        end
    end

    assign out_req_valid  = (count != 2'd0) ? slot_valid[rd_ptr] : '0;
    assign out_req_rw     = slot_rw[rd_ptr];
    assign out_req_addr   = slot_addr[rd_ptr];
    assign out_req_byteen = slot_byteen[rd_ptr];
    assign out_req_data   = slot_data[rd_ptr];
    assign out_req_tag    = slot_tag[rd_ptr];

    logic [SRC_BITS-1:0] rsp_src;
    logic                rsp_src_ok;

    assign rsp_src       = mem_rsp_tag[SRC_BITS-1:0];
    assign rsp_src_ok    = (int'(rsp_src) < NUM_INPUTS);
    assign mem_rsp_ready = rsp_src_ok ? in_rsp_ready[rsp_src] : 1'b1;

    always_comb begin
        in_rsp_valid = '0;
        for (int m = 0; m < NUM_INPUTS; m++) begin
            if (rsp_src_ok && rsp_src == SRC_BITS'(m)) in_rsp_valid[m] = mem_rsp_valid;
        end
    end

    for (genvar m = 0; m < NUM_INPUTS; m++) begin : g_rsp
        assign in_rsp_tmask[m*NUM_REQS +: NUM_REQS]               = mem_rsp_tmask;
        assign in_rsp_data[m*NUM_REQS*DATA_WIDTH +: NUM_REQS*DATA_WIDTH] = mem_rsp_data;
        assign in_rsp_tag[m*TAG_IN_WIDTH +: TAG_IN_WIDTH]         =
            mem_rsp_tag[TAG_OUT_WIDTH-1:SRC_BITS];
    end

    a_ready_lanes_equal: assert property (@(posedge clk) disable iff (!rst_ni)
        (out_req_ready == '0) || (out_req_ready == '1));
    a_rsp_src_in_range: assert property (@(posedge clk) disable iff (!rst_ni)
        mem_rsp_valid |-> rsp_src_ok);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_ni)
        accept |-> (count != 2'd2));

endmodule

// File: doc/smem_req_arb.md
Name: smem_req_arb

Overview:
- Upstream stage of the shared-memory block. Arbitrates whole-warp requests from NUM_INPUTS masters (e.g. LSU, DMA) onto the single NUM_REQS-lane shared-memory core request bus.
- Appends the source index to the tag on the request path.
- Demultiplexes each shared-memory response batch back to its owner by that tag field.
- Request path is registered through a 2-entry skid buffer. Response path is combinational.

Parameters:
- NUM_INPUTS, 2, number of requesting masters (>=2).
- NUM_REQS, 4, lanes per request.
- WORD_SIZE, 4, bytes per word.
- ADDR_WIDTH, 30, word address width.
- TAG_IN_WIDTH, 10, per-master tag width.
- SRC_BITS, derived: clog2(NUM_INPUTS).
- TAG_OUT_WIDTH, derived: TAG_IN_WIDTH+SRC_BITS.

Ports:
- clk  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_req_valid  in  NUM_INPUTS*NUM_REQS  per-master lane valid
- in_req_rw  in  NUM_INPUTS*NUM_REQS  1=write
- in_req_addr  in  NUM_INPUTS*NUM_REQS*ADDR_WIDTH  word address
- in_req_byteen  in  NUM_INPUTS*NUM_REQS*WORD_SIZE  byte enables
- in_req_data  in  NUM_INPUTS*NUM_REQS*8*WORD_SIZE  write data
- in_req_tag  in  NUM_INPUTS*NUM_REQS*TAG_IN_WIDTH  tag
- in_req_ready  out  NUM_INPUTS*NUM_REQS  per-lane ready
- out_req_valid/rw/addr/byteen/data  out  NUM_REQS*(same widths)  to shared memory
- out_req_tag  out  NUM_REQS*TAG_OUT_WIDTH  {tag, src}, src in LSBs
- out_req_ready  in  NUM_REQS  from shared memory (all lanes equal)
- mem_rsp_valid  in  1  shared-memory response
- mem_rsp_tmask  in  NUM_REQS  lane mask
- mem_rsp_data  in  NUM_REQS*8*WORD_SIZE  data
- mem_rsp_tag  in  TAG_OUT_WIDTH  tag
- mem_rsp_ready  out  1
- in_rsp_valid  out  NUM_INPUTS  per-master response valid
- in_rsp_tmask  out  NUM_INPUTS*NUM_REQS
- in_rsp_data  out  NUM_INPUTS*NUM_REQS*8*WORD_SIZE
- in_rsp_tag  out  NUM_INPUTS*TAG_IN_WIDTH  stripped tag
- in_rsp_ready  in  NUM_INPUTS

Behaviour:
- Master m is requesting when |in_req_valid[m] = 1.
- Round-robin grant: first requesting master at or after pointer rr_ptr, searching upward with wrap modulo NUM_INPUTS.
- rr_ptr reset value is 0. On an accepted batch from master g, rr_ptr <= (g+1) mod NUM_INPUTS, including the wrap at NUM_INPUTS-1 -> 0.
- Whole-batch atomic: in_req_ready[g][*] = buf_ready for all lanes of the granted master; all other masters see 0. Lanes with valid=0 still see ready, and their valid bits pass through as 0.
- Accept = granted master requesting && buf_ready.
- Skid buffer: 2 entries.
  - buf_ready is registered (true while fewer than 2 entries are held). It never depends combinationally on out_req_ready.
  - Accepted data is visible on out_req_* the next cycle: latency 1.
  - Full throughput of 1 batch/cycle while out_req_ready=1.
  - out_req_valid lanes are the stored lane-valid mask, gated by buffer-not-empty.
  - Output fields are held stable while valid && !ready.
- Output fire = (|out_req_valid) && out_req_ready[0].
- Tag: out_req_tag[l] = {in_req_tag[g][l], SRC_BITS'(g)}.
- Simultaneous accept and output fire with one entry held: count stays at 1. Accept with 2 entries held is impossible.
- No grant change on a cycle without accept; the pointer is held while stalled.
- Response routing:
  - src = mem_rsp_tag[SRC_BITS-1:0].
  - in_rsp_valid[src] = mem_rsp_valid; all other masters see 0.
  - tmask and data are broadcast to all masters.
  - in_rsp_tag[m] = mem_rsp_tag[TAG_OUT_WIDTH-1:SRC_BITS].
  - mem_rsp_ready = in_rsp_ready[src].
- A src value >= NUM_INPUTS (non-power-of-2 NUM_INPUTS): response is dropped, mem_rsp_ready=1, and a simulation assertion fires.
- Reset (async, any time, including mid-stall):
  - Buffer empties and rr_ptr=0.
  - out_req_valid=0 and in_req_ready=0 while rst_ni=0.
  - in_req_ready rises the first cycle after release.
  - Response outputs are combinational and follow their inputs.
- Assertion: out_req_ready lanes are all equal.

Test Plan:
- Single master: m0 sends lanes 1111, tag 0x05 -> next cycle out_req_valid=1111, out_req_tag=0x0A (0x05<<1|0); m1 ready=0.
- Contention, NUM_INPUTS=2, both valid continuously, out_req_ready=1 -> grants alternate m0,m1,m0,…; one batch per cycle; tags alternate src 0/1.
- Backpressure: out_req_ready=0 with continuous input -> exactly 2 batches accepted, then in_req_ready=0; outputs stable; on release, batches drain in order with no loss or duplication.
- Response routing: mem_rsp_tag=0x0B, valid, tmask 0101 -> in_rsp_valid=10, in_rsp_tag[1]=0x05; with in_rsp_ready[1]=0, mem_rsp_ready=0.
- Partial mask / wrap, NUM_INPUTS=3: only m2 then m0 requesting, lanes 0010 -> m2 granted, rr_ptr wraps to 0, m0 granted next; out_req_valid=0010 for the m2 batch.
- Reset mid-stall: buffer full, assert rst_ni=0 -> out_req_valid=0 immediately; after release, rr_ptr=0 and first grant goes to m0 when m0 and m1 both request.
